// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding and default widths.
// Optional feature macro used by this block: LSU_WRAP_ERR_EN.
package load_store_unit_pkg;

  localparam int LSU_AW = 8;
  localparam int LSU_DW = 8;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACC_LO = 2'd1,
    LSU_ACC_HI = 2'd2,
    LSU_RESP   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// CPU request/response channel plus the 8-bit data RAM pins of the load/store unit.
// Handshake: a request transfers on a rising edge where req_valid and req_ready are both
// high; the requester holds all req_* stable until then. resp_valid is a one-cycle
// pulse with no backpressure.
interface load_store_unit_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic            req_wide;
  logic [AW-1:0]   req_addr;
  logic [2*DW-1:0] req_wdata;
  logic            resp_valid;
  logic [2*DW-1:0] resp_rdata;
  logic            resp_err;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wr_data;
  logic            mem_write;
  logic            mem_read;
  logic [DW-1:0]   rd_data;

  // CPU plus RAM side
  modport master (
    output req_valid, req_we, req_wide, req_addr, req_wdata, rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  addr, wr_data, mem_write, mem_read
  );

  // load/store unit side
  modport slave (
    input  req_valid, req_we, req_wide, req_addr, req_wdata, rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output addr, wr_data, mem_write, mem_read
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: sequences byte or little-endian 16-bit accesses onto an 8-bit RAM port.
// Optional macro LSU_WRAP_ERR_EN: a wide access at the top address errors instead of wrapping.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int AW = LSU_AW,
  parameter int DW = LSU_DW
) (
  input  logic                clk,
  input  logic                rst,
  load_store_unit_if.slave    bus,
  output lsu_state_e          state_o
);

  lsu_state_e      state_q, state_d;
  logic            we_q, wide_q;
  logic [AW-1:0]   base_q;
  logic [2*DW-1:0] wdata_q;
  logic [DW-1:0]   data_lo_q, data_hi_q;
  logic            accept;
`ifdef LSU_WRAP_ERR_EN
  logic            err_q;
  logic            wrap_req;
  assign wrap_req = bus.req_wide && (bus.req_addr == {AW{1'b1}});
`endif

  assign state_o = state_q;

  // RAM pins decode from state and latched request only; req_* never reach them.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    bus.addr       = '0;
    bus.wr_data    = '0;
    bus.mem_write  = 1'b0;
    bus.mem_read   = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        bus.req_ready = rst;
        if (bus.req_valid && rst) begin
          accept  = 1'b1;
          state_d = LSU_ACC_LO;
`ifdef LSU_WRAP_ERR_EN
          if (wrap_req) state_d = LSU_RESP;
`endif
        end
      end
      LSU_ACC_LO: begin
        bus.addr      = base_q;
        bus.mem_write = we_q;
        bus.mem_read  = ~we_q;
        bus.wr_data   = wdata_q[DW-1:0];
        state_d       = wide_q ? LSU_ACC_HI : LSU_RESP;
      end
      LSU_ACC_HI: begin
        bus.addr      = base_q + {{(AW-1){1'b0}}, 1'b1};
        bus.mem_write = we_q;
        bus.mem_read  = ~we_q;
        bus.wr_data   = wdata_q[2*DW-1:DW];
        state_d       = LSU_RESP;
      end
      LSU_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = we_q ? '0 : {data_hi_q, data_lo_q};
`ifdef LSU_WRAP_ERR_EN
        bus.resp_err   = err_q;
`endif
        state_d        = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LSU_IDLE;
      we_q      <= 1'b0;
      wide_q    <= 1'b0;
      base_q    <= '0;
      wdata_q   <= '0;
      data_lo_q <= '0;
      data_hi_q <= '0;
`ifdef LSU_WRAP_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q      <= bus.req_we;
        wide_q    <= bus.req_wide;
        base_q    <= bus.req_addr;
        wdata_q   <= bus.req_wdata;
        // Cleared here so byte loads and errored accesses return zero upper bits.
        data_lo_q <= '0;
        data_hi_q <= '0;
`ifdef LSU_WRAP_ERR_EN
        err_q     <= wrap_req;
`endif
      end
      if (state_q == LSU_ACC_LO && !we_q) data_lo_q <= bus.rd_data;
      if (state_q == LSU_ACC_HI && !we_q) data_hi_q <= bus.rd_data;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit attached to a 256-byte behavioural data RAM.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  lsu_state_e state;
  int         n_assert = 0;
  int         n_fail = 0;

  load_store_unit_if #(.AW(8), .DW(8)) bus ();

  load_store_unit #(.AW(8), .DW(8)) dut (
    .clk     (clk),
    .rst     (rst_n),
    .bus     (bus.slave),
    .state_o (state)
  );

  always #5 clk = ~clk;

  // Data RAM: combinational read, synchronous write.
  logic [7:0] ram [256];
  always @(posedge clk) if (bus.mem_write) ram[bus.addr] <= bus.wr_data;
  assign bus.rd_data = bus.mem_read ? ram[bus.addr] : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to its response (bounded).
  // lat = negedges after the accept edge up to and including the response cycle.
  task automatic do_req(input logic we, input logic wide, input logic [7:0] a,
                        input logic [15:0] wd, output int lat, output logic [15:0] rdata,
                        output logic err, output int nwr, output logic [7:0] wa,
                        output logic [7:0] wdat);
    lat = 0; rdata = 'x; err = 'x; nwr = 0; wa = 0; wdat = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_wide = wide;
    bus.req_addr = a; bus.req_wdata = wd;
    #1 chk("accept_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      chk("rd_wr_excl", bus.mem_read & bus.mem_write, 1'b0);
      chk("busy_not_ready", bus.req_ready, 1'b0);
      if (bus.mem_write) begin nwr++; wa = bus.addr; wdat = bus.wr_data; end
      if (bus.resp_valid) begin
        lat = n; rdata = bus.resp_rdata; err = bus.resp_err;
        break;
      end
    end
  endtask

  int         lat, nwr;
  logic [15:0] rd;
  logic        er;
  logic [7:0]  wa, wdat;

  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_wide = 0; bus.req_addr = 0; bus.req_wdata = 0;

    // reset state
    #12;
    chk("rst_state", state, LSU_IDLE);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_mem_rw", {bus.mem_read, bus.mem_write}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", bus.req_ready, 1);

    // byte store then byte load
    do_req(1, 0, 8'h10, 16'h00A5, lat, rd, er, nwr, wa, wdat);
    chk("bst_lat", lat, 2);
    chk("bst_nwr", nwr, 1);
    chk("bst_waddr", wa, 8'h10);
    chk("bst_wdata", wdat, 8'hA5);
    chk("bst_rdata", rd, 0);
    chk("bst_err", er, 0);
    do_req(0, 0, 8'h10, 16'hFFFF, lat, rd, er, nwr, wa, wdat);
    chk("bld_lat", lat, 2);
    chk("bld_rdata", rd, 16'h00A5);
    chk("bld_nwr", nwr, 0);

    // wide store then wide load
    do_req(1, 1, 8'h20, 16'hBEEF, lat, rd, er, nwr, wa, wdat);
    chk("wst_lat", lat, 3);
    chk("wst_nwr", nwr, 2);
    chk("wst_ram20", ram[8'h20], 8'hEF);
    chk("wst_ram21", ram[8'h21], 8'hBE);
    do_req(0, 1, 8'h20, 16'h0000, lat, rd, er, nwr, wa, wdat);
    chk("wld_lat", lat, 3);
    chk("wld_rdata", rd, 16'hBEEF);
    // byte load of the high half is zero-extended
    do_req(0, 0, 8'h21, 16'h0000, lat, rd, er, nwr, wa, wdat);
    chk("bld_hi_rdata", rd, 16'h00BE);

    // wrap boundary
    do_req(1, 1, 8'hFF, 16'h1234, lat, rd, er, nwr, wa, wdat);
`ifdef LSU_WRAP_ERR_EN
    chk("wrap_lat", lat, 1);
    chk("wrap_nwr", nwr, 0);
    chk("wrap_err", er, 1);
    chk("wrap_rdata", rd, 0);
`else
    chk("wrap_lat", lat, 3);
    chk("wrap_nwr", nwr, 2);
    chk("wrap_err", er, 0);
    chk("wrap_ramff", ram[8'hFF], 8'h34);
    chk("wrap_ram00", ram[8'h00], 8'h12);
    do_req(0, 1, 8'hFF, 16'h0000, lat, rd, er, nwr, wa, wdat);
    chk("wrap_ld_rdata", rd, 16'h1234);
`endif

    // back-to-back requests with req_valid held high
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 1; bus.req_wide = 1; bus.req_addr = 8'h30; bus.req_wdata = 16'h1357;
    #1 chk("hs_ready0", bus.req_ready, 1);
    @(posedge clk);
    #1 bus.req_we = 0; bus.req_wdata = 16'h0000;
    @(negedge clk); chk("hs_st1", state, LSU_ACC_LO); chk("hs_rdy1", bus.req_ready, 0);
    @(negedge clk); chk("hs_st2", state, LSU_ACC_HI); chk("hs_rdy2", bus.req_ready, 0);
    @(negedge clk); chk("hs_st3", state, LSU_RESP); chk("hs_rdy3", bus.req_ready, 0);
    chk("hs_resp3", bus.resp_valid, 1);
    @(negedge clk); chk("hs_st4", state, LSU_IDLE); chk("hs_rdy4", bus.req_ready, 1);
    @(posedge clk);
    #1 bus.req_valid = 0;
    @(negedge clk); chk("hs_st5", state, LSU_ACC_LO); chk("hs_rd5", bus.mem_read, 1);
    @(negedge clk); chk("hs_st6", state, LSU_ACC_HI);
    @(negedge clk); chk("hs_resp7", bus.resp_valid, 1); chk("hs_rdata7", bus.resp_rdata, 16'h1357);

    // reset mid-access: preset RAM[0x41], then abort a wide store in ACC_HI
    do_req(1, 0, 8'h41, 16'h0077, lat, rd, er, nwr, wa, wdat);
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 1; bus.req_wide = 1; bus.req_addr = 8'h40; bus.req_wdata = 16'hCAFE;
    @(posedge clk);
    #1 bus.req_valid = 0;
    @(negedge clk); chk("mr_acclo", state, LSU_ACC_LO); chk("mr_wr_lo", bus.mem_write, 1);
    @(negedge clk); chk("mr_acchi", state, LSU_ACC_HI); chk("mr_addr_hi", bus.addr, 8'h41);
    rst_n = 0;
    #1;
    chk("mr_state", state, LSU_IDLE);
    chk("mr_outs", {bus.req_ready, bus.resp_valid, bus.mem_write, bus.mem_read}, 0);
    chk("mr_addr", bus.addr, 0);
    chk("mr_wrdata", bus.wr_data, 0);
    chk("mr_rdata", bus.resp_rdata, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("mr_no_resp", bus.resp_valid, 0);
    end
    rst_n = 1;
    @(negedge clk);
    chk("mr_rel_ready", bus.req_ready, 1);
    chk("mr_rel_resp", bus.resp_valid, 0);
    chk("mr_ram40", ram[8'h40], 8'hFE);
    chk("mr_ram41", ram[8'h41], 8'h77);
    do_req(0, 1, 8'h40, 16'h0000, lat, rd, er, nwr, wa, wdat);
    chk("mr_ld_rdata", rd, 16'h77FE);

    // idle quiet
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_addr", bus.addr, 0);
      chk("idle_rw", {bus.mem_read, bus.mem_write}, 0);
      chk("idle_resp", bus.resp_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
